// File: rtl/ready_list_ctrl.sv
// Ready-list scheduler: per-slot ready bit and priority, scanned one slot per cycle on each tick.
// Define READY_LIST_RR_EN to rotate ptr_nexttask_out among ready slots sharing the top priority.
module ready_list_ctrl #(
    parameter int         NTASKS   = 16,
    parameter logic [7:0] IDLE_PTR = 8'hFF
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       tick_in,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_id,
    input  logic [5:0] cmd_prio,
    output logic [5:0] highpriority_out,
    output logic [7:0] ptr_hpritask_out,
    output logic [7:0] ptr_nexttask_out,
    output logic       sched_valid,
    output logic       idle_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAST_SLOT = 4'(NTASKS - 1);

    state_t            state;
    state_t            state_nxt;
    logic              tick_q;
    logic              tick_event;
    logic              pending;
    logic [3:0]        slot;
    logic              last_slot;
    logic              cmd_accept;
    logic              cmd_in_range;

    logic [NTASKS-1:0] ready;
    logic [5:0]        prio [NTASKS];

    logic              cur_rdy;
    logic [5:0]        cur_prio;

    logic              h_found;
    logic [5:0]        h_prio;
    logic [3:0]        h_idx;
    logic              h_found_nxt;
    logic [5:0]        h_prio_nxt;
    logic [3:0]        h_idx_nxt;
    logic [7:0]        next_ptr;

    assign tick_event   = tick_in & ~tick_q;
    assign last_slot    = (slot == LAST_SLOT);
    assign cmd_accept   = cmd_valid & cmd_ready;
    assign cmd_in_range = ({1'b0, cmd_id} < 5'(NTASKS));
    assign cur_rdy      = ready[slot];
    assign cur_prio     = prio[slot];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (tick_event) state_nxt = SCAN;
            end
            SCAN: begin
                if (last_slot) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = (pending || tick_event) ? SCAN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Highest-priority tracker; slot 0 starts a fresh scan so stale results are ignored.
    always_comb begin
        h_found_nxt = (slot == 4'd0) ? 1'b0 : h_found;
        h_prio_nxt  = h_prio;
        h_idx_nxt   = h_idx;
        if (cur_rdy && (!h_found_nxt || (cur_prio > h_prio_nxt))) begin
            h_found_nxt = 1'b1;
            h_prio_nxt  = cur_prio;
            h_idx_nxt   = slot;
        end
    end

`ifdef READY_LIST_RR_EN
    logic       a_found;
    logic [5:0] a_prio;
    logic [3:0] a_idx;
    logic       a_found_nxt;
    logic [5:0] a_prio_nxt;
    logic [3:0] a_idx_nxt;

    // Round-robin tracker: best candidate strictly after the slot dispatched last time.
    always_comb begin
        a_found_nxt = (slot == 4'd0) ? 1'b0 : a_found;
        a_prio_nxt  = a_prio;
        a_idx_nxt   = a_idx;
        if (cur_rdy && ({4'b0000, slot} > ptr_nexttask_out) &&
            (!a_found_nxt || (cur_prio > a_prio_nxt))) begin
            a_found_nxt = 1'b1;
            a_prio_nxt  = cur_prio;
            a_idx_nxt   = slot;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            a_found <= 1'b0;
            a_prio  <= '0;
            a_idx   <= '0;
        end else if (state == SCAN) begin
            a_found <= a_found_nxt;
            a_prio  <= a_prio_nxt;
            a_idx   <= a_idx_nxt;
        end
    end

    assign next_ptr = (a_found_nxt && (a_prio_nxt == h_prio_nxt)) ?
                      {4'b0000, a_idx_nxt} : {4'b0000, h_idx_nxt};
`else
    assign next_ptr = {4'b0000, h_idx_nxt};
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tick_q  <= 1'b0;
            pending <= 1'b0;
            slot    <= '0;
            h_found <= 1'b0;
            h_prio  <= '0;
            h_idx   <= '0;
        end else begin
            tick_q <= tick_in;
            if (state == DONE) begin
                pending <= 1'b0;
            end else if ((state == SCAN) && tick_event) begin
                pending <= 1'b1;
            end
            if ((state == SCAN) && !last_slot) begin
                slot <= slot + 4'd1;
            end else begin
                slot <= '0;
            end
            if (state == SCAN) begin
                h_found <= h_found_nxt;
                h_prio  <= h_prio_nxt;
                h_idx   <= h_idx_nxt;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ready <= '0;
            for (int i = 0; i < NTASKS; i++) prio[i] <= '0;
        end else if (cmd_accept && cmd_in_range) begin
            case (cmd_op)
                2'b00:   ready[cmd_id] <= 1'b1;
                2'b01:   ready[cmd_id] <= 1'b0;
                2'b10:   prio[cmd_id]  <= cmd_prio;
                default: ;
            endcase
        end
    end

    // Results land on the edge that finishes the last slot, so they are visible in DONE.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sched_valid      <= 1'b0;
            idle_out         <= 1'b1;
            highpriority_out <= '0;
            ptr_hpritask_out <= IDLE_PTR;
            ptr_nexttask_out <= IDLE_PTR;
        end else if ((state == SCAN) && last_slot) begin
            sched_valid <= 1'b1;
            if (h_found_nxt) begin
                idle_out         <= 1'b0;
                highpriority_out <= h_prio_nxt;
                ptr_hpritask_out <= {4'b0000, h_idx_nxt};
                ptr_nexttask_out <= next_ptr;
            end else begin
                idle_out         <= 1'b1;
                highpriority_out <= '0;
                ptr_hpritask_out <= IDLE_PTR;
                ptr_nexttask_out <= IDLE_PTR;
            end
        end else begin
            sched_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ready_list_ctrl.sv
// Directed testbench for ready_list_ctrl (default NTASKS=16, IDLE_PTR=8'hFF).
module tb_ready_list_ctrl;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic       tick_in = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b11;
    logic [3:0] cmd_id = 4'd0;
    logic [5:0] cmd_prio = 6'd0;
    logic [5:0] highpriority_out;
    logic [7:0] ptr_hpritask_out;
    logic [7:0] ptr_nexttask_out;
    logic       sched_valid;
    logic       idle_out;

    int vectors = 0;
    int miscompares = 0;

    ready_list_ctrl #(.NTASKS(16), .IDLE_PTR(8'hFF)) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .tick_in(tick_in),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_id(cmd_id),
        .cmd_prio(cmd_prio),
        .highpriority_out(highpriority_out),
        .ptr_hpritask_out(ptr_hpritask_out),
        .ptr_nexttask_out(ptr_nexttask_out),
        .sched_valid(sched_valid),
        .idle_out(idle_out)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [5:0] hp, input logic [7:0] ph,
                           input logic [7:0] pn, input logic idl);
        chk({tag, "_hp"}, 32'(highpriority_out), 32'(hp));
        chk({tag, "_ph"}, 32'(ptr_hpritask_out), 32'(ph));
        chk({tag, "_pn"}, 32'(ptr_nexttask_out), 32'(pn));
        chk({tag, "_idle"}, 32'(idle_out), 32'(idl));
    endtask

    task automatic cmd(input logic [1:0] op, input logic [3:0] id, input logic [5:0] pr);
        cmd_valid = 1'b1; cmd_op = op; cmd_id = id; cmd_prio = pr;
        @(posedge aclk); #1;
        cmd_valid = 1'b0;
    endtask

    // Raises tick (optionally with a command in the same cycle) and counts edges to sched_valid.
    task automatic tick_wait(input bit with_cmd, input logic [1:0] op, input logic [3:0] id,
                             input logic [5:0] pr, output int lat);
        tick_in = 1'b1;
        cmd_valid = with_cmd; cmd_op = op; cmd_id = id; cmd_prio = pr;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge aclk); #1;
            cmd_valid = 1'b0;
            if (i == 3) tick_in = 1'b0;
            if (sched_valid) begin
                lat = i;
                break;
            end
        end
        tick_in = 1'b0;
    endtask

    task automatic to_idle();
        @(posedge aclk); #1;
    endtask

    int lat;
    int first_i;
    int rdy_i;
    int pulses;
    int p1;
    int p2;
    bit acc_pending;
    logic [7:0] exp_rr [3];

    initial begin
`ifdef READY_LIST_RR_EN
        exp_rr[0] = 8'd3; exp_rr[1] = 8'd4; exp_rr[2] = 8'd3;
`else
        exp_rr[0] = 8'd3; exp_rr[1] = 8'd3; exp_rr[2] = 8'd3;
`endif
        // Reset values
        repeat (2) @(posedge aclk);
        #1;
        chk_out("rst", 6'h00, 8'hFF, 8'hFF, 1'b1);
        chk("rst_sched_valid", 32'(sched_valid), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge aclk) aresetn = 1'b1;

        // Empty table: idle result after 17 cycles
        tick_wait(1'b0, 2'b11, 4'd0, 6'd0, lat);
        chk("empty_latency", 32'(lat), 32'd17);
        chk_out("empty", 6'h00, 8'hFF, 8'hFF, 1'b1);
        chk("empty_done_cmd_ready", 32'(cmd_ready), 32'd0);
        to_idle();
        chk("sched_valid_one_cycle", 32'(sched_valid), 32'd0);
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        // Slots 3 (0x0b) and 6 (0x03) ready
        cmd(2'b10, 4'd3, 6'h0b);
        cmd(2'b10, 4'd6, 6'h03);
        cmd(2'b00, 4'd3, 6'h00);
        cmd(2'b00, 4'd6, 6'h00);
        tick_wait(1'b0, 2'b11, 4'd0, 6'd0, lat);
        chk("two_ready_latency", 32'(lat), 32'd17);
        chk_out("two_ready", 6'h0b, 8'd3, 8'd3, 1'b0);
        to_idle();

        // Lower slot 3 to 0x01 in the same cycle as the tick: the scan must see it
        tick_wait(1'b1, 2'b10, 4'd3, 6'h01, lat);
        chk("cmd_with_tick_latency", 32'(lat), 32'd17);
        chk_out("cmd_with_tick", 6'h03, 8'd6, 8'd6, 1'b0);
        to_idle();

        // Fresh table: slots 3 and 4 at priority 5, three ticks
        @(negedge aclk) aresetn = 1'b0;
        @(negedge aclk) aresetn = 1'b1;
        cmd(2'b10, 4'd3, 6'd5);
        cmd(2'b10, 4'd4, 6'd5);
        cmd(2'b00, 4'd3, 6'd0);
        cmd(2'b00, 4'd4, 6'd0);
        for (int t = 0; t < 3; t++) begin
            tick_wait(1'b0, 2'b11, 4'd0, 6'd0, lat);
            chk($sformatf("rr%0d_latency", t), 32'(lat), 32'd17);
            chk_out($sformatf("rr%0d", t), 6'd5, 8'd3, exp_rr[t], 1'b0);
            to_idle();
        end

        // Command issued mid-scan waits for IDLE, then is applied
        tick_in = 1'b1;
        first_i = 0; rdy_i = 0; acc_pending = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge aclk); #1;
            if (i == 3) tick_in = 1'b0;
            if (acc_pending) begin
                cmd_valid = 1'b0;
                break;
            end
            if (cmd_valid && cmd_ready) begin
                acc_pending = 1'b1;
                rdy_i = i;
            end
            if (i == 4) begin
                chk("scan_cmd_ready", 32'(cmd_ready), 32'd0);
                cmd_valid = 1'b1; cmd_op = 2'b10; cmd_id = 4'd4; cmd_prio = 6'd9;
            end
            if (sched_valid && first_i == 0) begin
                first_i = i;
                chk("held_cmd_done_ready", 32'(cmd_ready), 32'd0);
                chk_out("held_cmd_scan", 6'd5, 8'd3, exp_rr[1], 1'b0);
            end
        end
        cmd_valid = 1'b0;
        chk("held_cmd_done_cycle", 32'(first_i), 32'd17);
        chk("held_cmd_ready_cycle", 32'(rdy_i), 32'd18);
        tick_wait(1'b0, 2'b11, 4'd0, 6'd0, lat);
        chk("held_cmd_applied_latency", 32'(lat), 32'd17);
        chk_out("held_cmd_applied", 6'd9, 8'd4, 8'd4, 1'b0);
        to_idle();

        // Two tick edges mid-scan coalesce into exactly one back-to-back rescan
        tick_in = 1'b1;
        pulses = 0; p1 = 0; p2 = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge aclk); #1;
            tick_in = (i <= 2) || (i >= 6 && i <= 7) || (i >= 10 && i <= 11);
            if (i == 18) chk("rescan_no_idle", 32'(cmd_ready), 32'd0);
            if (sched_valid) begin
                pulses++;
                if (pulses == 1) p1 = i;
                if (pulses == 2) begin
                    p2 = i;
                    chk_out("rescan", 6'd9, 8'd4, 8'd4, 1'b0);
                end
            end
        end
        chk("rescan_pulses", 32'(pulses), 32'd2);
        chk("rescan_first", 32'(p1), 32'd17);
        chk("rescan_second", 32'(p2), 32'd34);

        // Reset at scan slot 8 aborts without an update
        tick_in = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(posedge aclk); #1;
            if (i == 3) tick_in = 1'b0;
        end
        aresetn = 1'b0;
        #1;
        chk_out("abort_rst", 6'h00, 8'hFF, 8'hFF, 1'b1);
        chk("abort_rst_sched_valid", 32'(sched_valid), 32'd0);
        chk("abort_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge aclk) aresetn = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 25; i++) begin
            @(posedge aclk); #1;
            if (sched_valid) pulses++;
        end
        chk("abort_no_sched", 32'(pulses), 32'd0);
        chk_out("abort_after", 6'h00, 8'hFF, 8'hFF, 1'b1);

        // tick_in already high at reset release is a tick on the first cycle
        @(negedge aclk) begin aresetn = 1'b0; tick_in = 1'b1; end
        @(negedge aclk) aresetn = 1'b1;
        tick_wait(1'b0, 2'b11, 4'd0, 6'd0, lat);
        chk("tick_at_release_latency", 32'(lat), 32'd17);
        chk_out("tick_at_release", 6'h00, 8'hFF, 8'hFF, 1'b1);
        to_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
